// File: rtl/snake_pkg.sv
// snake_pkg: grid defaults, coordinate types and food_spawner state encodings shared by the game.
package snake_pkg;

   localparam int GRID_W_DEF    = 32;
   localparam int GRID_H_DEF    = 24;
   localparam int XW_DEF        = 5;
   localparam int YW_DEF        = 5;
   localparam int MAX_TRIES_DEF = 16;

   typedef logic [XW_DEF-1:0] coord_x_t;
   typedef logic [YW_DEF-1:0] coord_y_t;

   localparam logic [2:0] ST_IDLE    = 3'd0;
   localparam logic [2:0] ST_COLLECT = 3'd1;
   localparam logic [2:0] ST_RANGE   = 3'd2;
   localparam logic [2:0] ST_QUERY   = 3'd3;
   localparam logic [2:0] ST_DONE    = 3'd4;
   localparam logic [2:0] ST_SCAN    = 3'd5;

endpackage

// File: rtl/rand_collector.sv
// rand_collector: shifts N serial random bits in MSB-first and flags the Nth one.
// Latency: done is asserted combinationally with the Nth enabled bit; data valid the cycle after.
// Backpressure: none, shifts on every shift_en cycle; start restarts the bit count.
module rand_collector #(
   parameter int N = 10
)(
   input  logic         clk,
   input  logic         rst_n,
   input  logic         start,
   input  logic         shift_en,
   input  logic         bit_in,
   output logic [N-1:0] data,
   output logic         done
);

   localparam int CW = $clog2(N + 1);

   logic [CW-1:0] cnt;

   assign done = shift_en && (cnt == CW'(N - 1));

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt  <= '0;
         data <= '0;
      end else begin
         if (start)
            cnt <= '0;
         else if (shift_en)
            cnt <= done ? '0 : cnt + CW'(1);
         if (shift_en)
            data <= {data[N-2:0], bit_in};
      end
   end

endmodule

// File: rtl/food_spawner.sv
// food_spawner: draws X/Y from the LFSR stream, range-checks and occupancy-checks it, presents free food cell.
// Latency: XW+YW+4 cycles spawn_req->food_valid at best; every rejection costs a fresh draw.
// Backpressure: spawn_req ignored while busy; occ query held until occ_ack. FOOD_SCAN_FALLBACK_EN adds scan.
module food_spawner
   import snake_pkg::*;
#(
   parameter int GRID_W = GRID_W_DEF,
   parameter int GRID_H = GRID_H_DEF,
   parameter int XW     = XW_DEF,
   parameter int YW     = YW_DEF
`ifdef FOOD_SCAN_FALLBACK_EN
   ,
   parameter int MAX_TRIES = MAX_TRIES_DEF
`endif
)(
   input  logic          clk,
   input  logic          rst_n,
   input  logic          spawn_req,
   input  logic          rand_bit,
   output logic          rand_en,
   output logic          occ_req,
   output logic [XW-1:0] occ_x,
   output logic [YW-1:0] occ_y,
   input  logic          occ_ack,
   input  logic          occ_hit,
   output logic [XW-1:0] food_x,
   output logic [YW-1:0] food_y,
   output logic          food_valid,
   output logic          busy,
   output logic          grid_full
);

   localparam int NB = XW + YW;

   logic [2:0]    state;
   logic [NB-1:0] cand;
   logic          col_done;
   logic          accept;
   logic          in_range;
   logic          reject;
   logic [XW-1:0] cand_x;
   logic [YW-1:0] cand_y;

   assign accept   = spawn_req && (state == ST_IDLE);
   assign rand_en  = (state == ST_COLLECT);
   assign busy     = (state != ST_IDLE);
   assign cand_x   = cand[NB-1 -: XW];
   assign cand_y   = cand[YW-1:0];
   assign in_range = (32'(cand_x) < GRID_W) && (32'(cand_y) < GRID_H);
   assign reject   = ((state == ST_RANGE) && !in_range) ||
                     ((state == ST_QUERY) && occ_ack && occ_hit);

   rand_collector #(.N(NB)) u_collector (
      .clk      (clk),
      .rst_n    (rst_n),
      .start    (accept),
      .shift_en (rand_en),
      .bit_in   (rand_bit),
      .data     (cand),
      .done     (col_done)
   );

`ifdef FOOD_SCAN_FALLBACK_EN
   localparam int CELLS = GRID_W * GRID_H;
   localparam int TW    = $clog2(MAX_TRIES + 1);
   localparam int SW    = $clog2(CELLS + 1);

   logic [TW-1:0] tries;
   logic [SW-1:0] scan_cnt;
   logic          last_try;
   logic          scan_last;
   logic [XW-1:0] base_x, nxt_x;
   logic [YW-1:0] base_y, nxt_y;

   assign occ_req   = (state == ST_QUERY) || (state == ST_SCAN);
   assign last_try  = (tries == TW'(MAX_TRIES - 1));
   assign scan_last = (scan_cnt == SW'(CELLS - 1));

   // An out-of-range draw has no usable position, so the scan then starts from the origin.
   always_comb begin
      base_x = (state == ST_RANGE) ? '0 : occ_x;
      base_y = (state == ST_RANGE) ? '0 : occ_y;
      nxt_x  = base_x;
      nxt_y  = base_y;
      if (32'(base_x) >= GRID_W - 1) begin
         nxt_x = '0;
         nxt_y = (32'(base_y) >= GRID_H - 1) ? '0 : base_y + YW'(1);
      end else begin
         nxt_x = base_x + XW'(1);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         tries     <= '0;
         scan_cnt  <= '0;
         grid_full <= 1'b0;
      end else begin
         grid_full <= 1'b0;
         if (accept)
            tries <= '0;
         else if (reject && !last_try)
            tries <= tries + TW'(1);
         if (reject)
            scan_cnt <= '0;
         else if ((state == ST_SCAN) && occ_ack && occ_hit) begin
            scan_cnt <= scan_cnt + SW'(1);
            if (scan_last)
               grid_full <= 1'b1;
         end
      end
   end
`else
   assign occ_req   = (state == ST_QUERY);
   assign grid_full = 1'b0;
`endif

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state      <= ST_IDLE;
         occ_x      <= '0;
         occ_y      <= '0;
         food_x     <= '0;
         food_y     <= '0;
         food_valid <= 1'b0;
      end else begin
         case (state)
            ST_IDLE: begin
               if (spawn_req) begin
                  state      <= ST_COLLECT;
                  food_valid <= 1'b0;
               end
            end
            ST_COLLECT: begin
               if (col_done)
                  state <= ST_RANGE;
            end
            ST_RANGE: begin
               if (in_range) begin
                  occ_x <= cand_x;
                  occ_y <= cand_y;
                  state <= ST_QUERY;
               end
            end
            ST_QUERY: begin
               if (occ_ack && !occ_hit)
                  state <= ST_DONE;
            end
            ST_DONE: begin
               food_x     <= occ_x;
               food_y     <= occ_y;
               food_valid <= 1'b1;
               state      <= ST_IDLE;
            end
`ifdef FOOD_SCAN_FALLBACK_EN
            ST_SCAN: begin
               if (occ_ack) begin
                  if (!occ_hit)
                     state <= ST_DONE;
                  else if (scan_last)
                     state <= ST_IDLE;
                  else begin
                     occ_x <= nxt_x;
                     occ_y <= nxt_y;
                  end
               end
            end
`endif
            default: state <= ST_IDLE;
         endcase

         if (reject) begin
`ifdef FOOD_SCAN_FALLBACK_EN
            if (last_try) begin
               state <= ST_SCAN;
               occ_x <= nxt_x;
               occ_y <= nxt_y;
            end else begin
               state <= ST_COLLECT;
            end
`else
            state <= ST_COLLECT;
`endif
         end
      end
   end

endmodule

// File: tb/tb_food_spawner.sv
// tb_food_spawner: scoreboard bench for food_spawner; LFSR and occupancy responder are modelled here.
// Build with FOOD_SCAN_FALLBACK_EN to also cover the scan fallback and grid_full.
module tb_food_spawner;

   localparam int XW     = 5;
   localparam int YW     = 5;
   localparam int NB     = XW + YW;
   localparam int GRID_W = 32;
   localparam int GRID_H = 24;

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic          spawn_req = 1'b0;
   logic          rand_bit = 1'b0;
   logic          occ_ack = 1'b0;
   logic          occ_hit = 1'b0;
   logic          rand_en, occ_req, food_valid, busy, grid_full;
   logic [XW-1:0] occ_x, food_x;
   logic [YW-1:0] occ_y, food_y;

   int n_tests = 0;
   int n_fail  = 0;

   bit bitq[$];
   int exp_q[$];
   bit occ_map [32][32];

   int ack_dly    = 1;
   int rand_cnt   = 0;
   int n_query    = 0;
   int n_food     = 0;
   int n_full     = 0;
   int stable_err = 0;
   bit consume    = 1'b0;
   bit fv_d       = 1'b0;
   logic [XW-1:0] qx;
   logic [YW-1:0] qy;

   always #5 clk = ~clk;

   food_spawner #(
      .GRID_W (GRID_W),
      .GRID_H (GRID_H),
      .XW     (XW),
      .YW     (YW)
`ifdef FOOD_SCAN_FALLBACK_EN
      ,
      .MAX_TRIES (4)
`endif
   ) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .spawn_req  (spawn_req),
      .rand_bit   (rand_bit),
      .rand_en    (rand_en),
      .occ_req    (occ_req),
      .occ_x      (occ_x),
      .occ_y      (occ_y),
      .occ_ack    (occ_ack),
      .occ_hit    (occ_hit),
      .food_x     (food_x),
      .food_y     (food_y),
      .food_valid (food_valid),
      .busy       (busy),
      .grid_full  (grid_full)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_tests++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
      end
   endtask

   task automatic push_draw(input int x, input int y);
      for (int i = XW - 1; i >= 0; i--) bitq.push_back(x[i]);
      for (int i = YW - 1; i >= 0; i--) bitq.push_back(y[i]);
   endtask

   task automatic exp_push(input int x, input int y);
      exp_q.push_back((x << YW) | y);
   endtask

   // Called on a falling edge; returns spawn-to-food_valid latency in clock edges.
   task automatic spawn_wait(input string tag, input int budget, output int lat);
      int n;
      spawn_req = 1'b1;
      @(negedge clk);
      spawn_req = 1'b0;
      n = 1;
      while (!food_valid && n < budget) begin
         @(negedge clk);
         n++;
      end
      lat = n - 1;
      chk({tag, "_valid"}, food_valid, 1);
      chk({tag, "_idle"}, busy, 0);
   endtask

   task automatic wait_idle(input string tag, input int budget);
      for (int i = 0; i < budget && busy; i++) @(negedge clk);
      chk({tag, "_idle"}, busy, 0);
   endtask

   // LFSR model, cycle counter and food scoreboard.
   initial forever begin
      int e;
      @(negedge clk);
      if (consume && bitq.size() != 0) void'(bitq.pop_front());
      rand_bit = (bitq.size() != 0) ? bitq[0] : 1'b0;
      consume  = rand_en;
      if (rand_en) rand_cnt++;
      if (grid_full) n_full++;
      if (food_valid && !fv_d) begin
         n_food++;
         if (exp_q.size() == 0)
            chk("food_unexpected", exp_q.size(), 1);
         else begin
            e = exp_q.pop_front();
            chk("food_xy", {22'd0, food_x, food_y}, e);
         end
      end
      fv_d = food_valid;
   end

   // Occupancy responder: acks ack_dly cycles after a request is seen, checks coordinates hold.
   initial forever begin
      @(negedge clk);
      occ_ack = 1'b0;
      occ_hit = 1'b0;
      if (occ_req) begin
         qx = occ_x;
         qy = occ_y;
         for (int i = 0; i < ack_dly; i++) begin
            @(negedge clk);
            if (occ_req && (occ_x !== qx || occ_y !== qy)) stable_err++;
         end
         if (occ_req) begin
            occ_ack = 1'b1;
            occ_hit = occ_map[qx][qy];
            n_query++;
         end
      end
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      int lat;
      int n0;
      foreach (occ_map[i, j]) occ_map[i][j] = 1'b0;

      repeat (3) @(negedge clk);
      chk("rst_rand_en", rand_en, 0);
      chk("rst_occ_req", occ_req, 0);
      chk("rst_occ_x", occ_x, 0);
      chk("rst_occ_y", occ_y, 0);
      chk("rst_food_x", food_x, 0);
      chk("rst_food_y", food_y, 0);
      chk("rst_food_valid", food_valid, 0);
      chk("rst_busy", busy, 0);
      chk("rst_grid_full", grid_full, 0);
      rst_n = 1'b1;
      repeat (2) @(negedge clk);

      // Basic draw: 00011 00101 -> (3,5), minimum latency.
      push_draw(3, 5);
      exp_push(3, 5);
      rand_cnt = 0;
      spawn_wait("t1", 100, lat);
      chk("t1_latency", lat, NB + 4);
      chk("t1_rand_en_cycles", rand_cnt, NB);
      repeat (2) @(negedge clk);

      // Row out of range, then accepted.
      push_draw(7, 30);
      push_draw(7, 2);
      exp_push(7, 2);
      rand_cnt = 0;
      spawn_wait("t2a", 200, lat);
      chk("t2a_rand_en_cycles", rand_cnt, 2 * NB);

      // Boundary: last column is always legal, row GRID_H rejected, GRID_H-1 accepted.
      push_draw(31, 24);
      push_draw(31, 23);
      exp_push(31, 23);
      rand_cnt = 0;
      spawn_wait("t2b", 200, lat);
      chk("t2b_rand_en_cycles", rand_cnt, 2 * NB);

      // Occupied cell rejected, slow responder checks request stability.
      occ_map[3][5] = 1'b1;
      ack_dly = 3;
      push_draw(3, 5);
      push_draw(4, 9);
      exp_push(4, 9);
      rand_cnt = 0;
      n_query  = 0;
      stable_err = 0;
      spawn_wait("t3", 200, lat);
      chk("t3_queries", n_query, 2);
      chk("t3_occ_stable", stable_err, 0);
      chk("t3_rand_en_cycles", rand_cnt, 2 * NB);
      occ_map[3][5] = 1'b0;
      repeat (2) @(negedge clk);

      // spawn_req while busy is dropped; exactly one result.
      ack_dly = 5;
      push_draw(10, 20);
      exp_push(10, 20);
      rand_cnt = 0;
      n0 = n_food;
      spawn_req = 1'b1;
      @(negedge clk);
      spawn_req = 1'b0;
      repeat (3) @(negedge clk);
      spawn_req = 1'b1;
      @(negedge clk);
      spawn_req = 1'b0;
      for (int i = 0; i < 40 && !occ_req; i++) @(negedge clk);
      chk("t4_in_query", occ_req, 1);
      spawn_req = 1'b1;
      @(negedge clk);
      spawn_req = 1'b0;
      wait_idle("t4", 100);
      repeat (20) @(negedge clk);
      chk("t4_results", n_food - n0, 1);
      chk("t4_rand_en_cycles", rand_cnt, NB);
      chk("t4_still_idle", busy, 0);
      chk("t4_pending_exp", exp_q.size(), 0);

      // Asynchronous reset while a query is outstanding.
      push_draw(1, 1);
      spawn_req = 1'b1;
      @(negedge clk);
      spawn_req = 1'b0;
      for (int i = 0; i < 40 && !occ_req; i++) @(negedge clk);
      chk("t5_in_query", occ_req, 1);
      @(negedge clk);
      #2 rst_n = 1'b0;
      #1;
      chk("t5_rst_occ_req", occ_req, 0);
      chk("t5_rst_busy", busy, 0);
      chk("t5_rst_rand_en", rand_en, 0);
      chk("t5_rst_occ_xy", {occ_x, occ_y}, 0);
      chk("t5_rst_food_xy", {food_x, food_y}, 0);
      chk("t5_rst_food_valid", food_valid, 0);
      @(negedge clk);
      rst_n = 1'b1;
      ack_dly = 1;
      repeat (8) @(negedge clk);
      push_draw(2, 3);
      exp_push(2, 3);
      spawn_wait("t5", 100, lat);
      chk("t5_latency", lat, NB + 4);
      repeat (2) @(negedge clk);

`ifdef FOOD_SCAN_FALLBACK_EN
      // Four occupied draws switch to scan, which finds the single free cell.
      foreach (occ_map[i, j]) occ_map[i][j] = 1'b1;
      occ_map[0][1] = 1'b0;
      for (int k = 0; k < 4; k++) push_draw(5 + k, 5 + k);
      exp_push(0, 1);
      rand_cnt = 0;
      spawn_wait("t6a", 6000, lat);
      chk("t6a_rand_en_cycles", rand_cnt, 4 * NB);
      repeat (2) @(negedge clk);

      // Every cell occupied: one grid_full pulse, no food.
      occ_map[0][1] = 1'b1;
      for (int k = 0; k < 4; k++) push_draw(2 + k, 9 + k);
      n_full = 0;
      n0 = n_food;
      spawn_req = 1'b1;
      @(negedge clk);
      spawn_req = 1'b0;
      wait_idle("t6b", 6000);
      repeat (3) @(negedge clk);
      chk("t6b_grid_full_pulses", n_full, 1);
      chk("t6b_food_valid", food_valid, 0);
      chk("t6b_results", n_food - n0, 0);
`else
      chk("grid_full_tied", n_full, 0);
`endif

      chk("exp_queue_drained", exp_q.size(), 0);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
